// File: rtl/execute_stage_pkg.sv
// Shared types for the RV32I execute stage: ALU ops, operand selects,
// branch funct3 encodings and the forwarding match helper.
package execute_stage_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLL    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_SLT    = 4'd8,
    ALU_SLTU   = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRC_A_RS1  = 2'd0,
    SRC_A_PC   = 2'd1,
    SRC_A_ZERO = 2'd2
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RS2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2
  } alu_src_b_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // x0 is hardwired, so a producer targeting it never forwards
  function automatic logic fwd_hit(
    input logic       en,
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return en & (rd == rs) & (rs != 5'd0);
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU: op + A + B -> result.
// Unused op codes produce zero.
module execute_stage_alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o
);

  logic [4:0] shamt;

  always_comb begin
    result_o = '0;
    shamt    = b_i[4:0];
    case (op_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_OR:     result_o = a_i | b_i;
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:    result_o = {{(XLEN-1){1'b0}},
                              $signed(a_i) < $signed(b_i)};
      ALU_SLTU:   result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_PASS_B: result_o = b_i;
      default:    result_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution, EX/MEM register.
// Operand forwarding is built only when EXECUTE_FORWARD_EN is defined.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid_i,
  input  logic [3:0]      alu_control_i,
  input  logic [1:0]      alu_src_a_i,
  input  logic [1:0]      alu_src_b_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic            jalr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] rd2_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            reg_write_i,
  input  logic [3:0]      mem_write_i,
  input  logic [1:0]      result_src_i,
  input  logic            mem_fwd_en_i,
  input  logic [4:0]      mem_fwd_rd_i,
  input  logic [XLEN-1:0] mem_fwd_data_i,
  input  logic            wb_fwd_en_i,
  input  logic [4:0]      wb_fwd_rd_i,
  input  logic [XLEN-1:0] wb_fwd_data_i,
  input  logic            mem_stall_i,
  output logic            ex_ready_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            mem_valid_o,
  output logic            mem_reg_write_o,
  output logic [XLEN-1:0] mem_alu_result_o,
  output logic [XLEN-1:0] mem_write_data_o,
  output logic [4:0]      mem_rd_o,
  output logic [3:0]      mem_mem_write_o,
  output logic [1:0]      mem_result_src_o,
  output logic [2:0]      mem_funct3_o
);

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            cond;
  logic            live;
  logic            take;

  logic squash_q, squash_d;

  logic            valid_q, valid_d;
  logic            reg_write_q, reg_write_d;
  logic [3:0]      mem_write_q, mem_write_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [1:0]      result_src_q, result_src_d;
  logic [2:0]      funct3_q, funct3_d;

`ifdef EXECUTE_FORWARD_EN
  // MEM is the younger producer, so it wins over WB
  always_comb begin
    rs1_val = rd1_i;
    rs2_val = rd2_i;
    if (fwd_hit(mem_fwd_en_i, mem_fwd_rd_i, rs1_i))
      rs1_val = mem_fwd_data_i;
    else if (fwd_hit(wb_fwd_en_i, wb_fwd_rd_i, rs1_i))
      rs1_val = wb_fwd_data_i;
    if (fwd_hit(mem_fwd_en_i, mem_fwd_rd_i, rs2_i))
      rs2_val = mem_fwd_data_i;
    else if (fwd_hit(wb_fwd_en_i, wb_fwd_rd_i, rs2_i))
      rs2_val = wb_fwd_data_i;
  end
`else
  logic unused_fwd;

  assign rs1_val    = rd1_i;
  assign rs2_val    = rd2_i;
  assign unused_fwd = ^{rs1_i, rs2_i,
                        mem_fwd_en_i, mem_fwd_rd_i, mem_fwd_data_i,
                        wb_fwd_en_i, wb_fwd_rd_i, wb_fwd_data_i};
`endif

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (alu_src_a_i)
      SRC_A_RS1: op_a = rs1_val;
      SRC_A_PC:  op_a = pc_i;
      default:   op_a = '0;
    endcase
    case (alu_src_b_i)
      SRC_B_RS2:  op_b = rs2_val;
      SRC_B_IMM:  op_b = imm_i;
      SRC_B_FOUR: op_b = XLEN'(4);
      default:    op_b = '0;
    endcase
  end

  execute_stage_alu #(
    .XLEN(XLEN)
  ) u_alu (
    .op_i    (alu_control_i),
    .a_i     (op_a),
    .b_i     (op_b),
    .result_o(alu_res)
  );

  always_comb begin
    cond = 1'b0;
    case (funct3_i)
      F3_BEQ:  cond = (rs1_val == rs2_val);
      F3_BNE:  cond = (rs1_val != rs2_val);
      F3_BLT:  cond = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: cond = (rs1_val < rs2_val);
      F3_BGEU: cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum = rs1_val + imm_i;
  assign target   = jalr_i ? {jalr_sum[XLEN-1:1], 1'b0}
                           : pc_i + imm_i;

  assign live          = ex_valid_i & ~squash_q;
  assign take          = live & (jump_i | jalr_i | (branch_i & cond));
  assign redirect_o    = take & ~mem_stall_i & ~reset;
  assign redirect_pc_o = target;
  assign ex_ready_o    = ~mem_stall_i;

  // The wrong-path instruction sits in ID/EX until a non-stalled edge
  always_comb begin
    squash_d = squash_q;
    if (redirect_o)
      squash_d = 1'b1;
    else if (!mem_stall_i)
      squash_d = 1'b0;
  end

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    rd_d         = rd_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    result_src_d = result_src_q;
    funct3_d     = funct3_q;
    if (!mem_stall_i) begin
      valid_d      = live;
      reg_write_d  = live & reg_write_i;
      mem_write_d  = live ? mem_write_i : 4'b0;
      rd_d         = rd_i;
      alu_result_d = alu_res;
      write_data_d = rs2_val;
      result_src_d = result_src_i;
      funct3_d     = funct3_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      squash_q     <= 1'b0;
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= '0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      result_src_q <= '0;
      funct3_q     <= '0;
    end else begin
      squash_q     <= squash_d;
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      result_src_q <= result_src_d;
      funct3_q     <= funct3_d;
    end
  end

  assign mem_valid_o      = valid_q;
  assign mem_reg_write_o  = reg_write_q;
  assign mem_mem_write_o  = mem_write_q;
  assign mem_rd_o         = rd_q;
  assign mem_alu_result_o = alu_result_q;
  assign mem_write_data_o = write_data_q;
  assign mem_result_src_o = result_src_q;
  assign mem_funct3_o     = funct3_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table with a scoreboard,
// plus stall, squash, forwarding and reset sequences.
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        ex_valid_i;
  logic [3:0]  alu_control_i;
  logic [1:0]  alu_src_a_i;
  logic [1:0]  alu_src_b_i;
  logic        branch_i, jump_i, jalr_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i, rd1_i, rd2_i, imm_i;
  logic [4:0]  rs1_i, rs2_i, rd_i;
  logic        reg_write_i;
  logic [3:0]  mem_write_i;
  logic [1:0]  result_src_i;
  logic        mem_fwd_en_i;
  logic [4:0]  mem_fwd_rd_i;
  logic [31:0] mem_fwd_data_i;
  logic        wb_fwd_en_i;
  logic [4:0]  wb_fwd_rd_i;
  logic [31:0] wb_fwd_data_i;
  logic        mem_stall_i;
  logic        ex_ready_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic        mem_valid_o, mem_reg_write_o;
  logic [31:0] mem_alu_result_o, mem_write_data_o;
  logic [4:0]  mem_rd_o;
  logic [3:0]  mem_mem_write_o;
  logic [1:0]  mem_result_src_o;
  logic [2:0]  mem_funct3_o;

  execute_stage dut (
    .clk(clk), .reset(reset), .ex_valid_i(ex_valid_i),
    .alu_control_i(alu_control_i), .alu_src_a_i(alu_src_a_i),
    .alu_src_b_i(alu_src_b_i), .branch_i(branch_i), .jump_i(jump_i),
    .jalr_i(jalr_i), .funct3_i(funct3_i), .pc_i(pc_i), .rd1_i(rd1_i),
    .rd2_i(rd2_i), .imm_i(imm_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .rd_i(rd_i), .reg_write_i(reg_write_i), .mem_write_i(mem_write_i),
    .result_src_i(result_src_i), .mem_fwd_en_i(mem_fwd_en_i),
    .mem_fwd_rd_i(mem_fwd_rd_i), .mem_fwd_data_i(mem_fwd_data_i),
    .wb_fwd_en_i(wb_fwd_en_i), .wb_fwd_rd_i(wb_fwd_rd_i),
    .wb_fwd_data_i(wb_fwd_data_i), .mem_stall_i(mem_stall_i),
    .ex_ready_o(ex_ready_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o), .mem_valid_o(mem_valid_o),
    .mem_reg_write_o(mem_reg_write_o),
    .mem_alu_result_o(mem_alu_result_o),
    .mem_write_data_o(mem_write_data_o), .mem_rd_o(mem_rd_o),
    .mem_mem_write_o(mem_mem_write_o),
    .mem_result_src_o(mem_result_src_o), .mem_funct3_o(mem_funct3_o)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  sa, sb;
    logic        br, jp, jr;
    logic [2:0]  f3;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw;
    logic [3:0]  mw;
    logic [1:0]  rsrc;
    logic        valid;
    logic [31:0] res, wd;
    logic        take;
    logic [31:0] tgt;
  } vec_t;

  typedef struct {
    logic        valid, rw;
    logic [3:0]  mw;
    logic [4:0]  rd;
    logic [31:0] res, wd;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
  } exp_t;

  localparam logic [2:0] C_NONE = 3'b000;
  localparam logic [2:0] C_BR   = 3'b100;
  localparam logic [2:0] C_JAL  = 3'b010;
  localparam logic [2:0] C_JALR = 3'b001;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic sq     = 1'b0;
  exp_t sb[$];
  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sbs,
    input logic [2:0] ctl, input logic [2:0] f3, input logic [31:0] pc,
    input logic [31:0] rd1, input logic [31:0] rd2,
    input logic [31:0] imm, input logic [31:0] res,
    input logic take, input logic [31:0] tgt);
    vec_t v;
    v.op = op; v.sa = sa; v.sb = sbs;
    v.br = ctl[2]; v.jp = ctl[1]; v.jr = ctl[0];
    v.f3 = f3; v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.rs1 = 5'd1; v.rs2 = 5'd2; v.rd = 5'd10;
    v.rw = 1'b1; v.mw = 4'h0; v.rsrc = 2'd0; v.valid = 1'b1;
    v.res = res; v.wd = rd2; v.take = take; v.tgt = tgt;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ex_valid_i = v.valid; alu_control_i = v.op;
    alu_src_a_i = v.sa; alu_src_b_i = v.sb;
    branch_i = v.br; jump_i = v.jp; jalr_i = v.jr;
    funct3_i = v.f3; pc_i = v.pc; rd1_i = v.rd1; rd2_i = v.rd2;
    imm_i = v.imm; rs1_i = v.rs1; rs2_i = v.rs2; rd_i = v.rd;
    reg_write_i = v.rw; mem_write_i = v.mw; result_src_i = v.rsrc;
  endtask

  task automatic check_out(input string nm, input exp_t e);
    chk({nm, ".valid"}, mem_valid_o, e.valid);
    chk({nm, ".rw"}, mem_reg_write_o, e.rw);
    chk({nm, ".mw"}, mem_mem_write_o, e.mw);
    if (e.valid) begin
      chk({nm, ".res"}, mem_alu_result_o, e.res);
      chk({nm, ".wd"}, mem_write_data_o, e.wd);
      chk({nm, ".rd"}, mem_rd_o, e.rd);
      chk({nm, ".rsrc"}, mem_result_src_o, e.rsrc);
      chk({nm, ".f3"}, mem_funct3_o, e.f3);
    end
  endtask

  // Called at posedge+1; leaves time at the next posedge+1
  task automatic run_vec(input string nm, input vec_t v);
    exp_t e;
    logic tk;
    drive(v);
    mem_stall_i = 1'b0;
    #1;
    tk = v.valid & ~sq & v.take;
    chk({nm, ".redirect"}, redirect_o, tk);
    if (tk) chk({nm, ".redirect_pc"}, redirect_pc_o, v.tgt);
    e.valid = v.valid & ~sq;
    e.rw    = e.valid & v.rw;
    e.mw    = e.valid ? v.mw : 4'h0;
    e.rd    = v.rd; e.res = v.res; e.wd = v.wd;
    e.rsrc  = v.rsrc; e.f3 = v.f3;
    sb.push_back(e);
    @(posedge clk);
    sq = tk;
    #1;
    check_out(nm, sb.pop_front());
  endtask

  initial begin
    vec_t v;
    vec_t z;
    z = mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 0, 0, 0, 0, 0, 0);
    z.valid = 1'b0; z.rw = 1'b0;
    drive(z);
    reset = 1'b1; mem_stall_i = 1'b0;
    mem_fwd_en_i = 0; mem_fwd_rd_i = 0; mem_fwd_data_i = 0;
    wb_fwd_en_i = 0; wb_fwd_rd_i = 0; wb_fwd_data_i = 0;

    tbl.push_back(mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 5, 7, 0,
                     32'd12, 0, 0));
    tbl[0].mw = 4'h3; tbl[0].rsrc = 2'd1; tbl[0].rd = 5'd3;
    tbl.push_back(mk(ALU_SUB, 0, 0, C_NONE, 0, 0, 5, 7, 0,
                     32'hFFFF_FFFE, 0, 0));
    tbl.push_back(mk(ALU_AND, 0, 0, C_NONE, 0, 0, 32'hF0F0,
                     32'hFF00, 0, 32'hF000, 0, 0));
    tbl.push_back(mk(ALU_OR, 0, 0, C_NONE, 0, 0, 32'hF0F0,
                     32'hFF00, 0, 32'hFFF0, 0, 0));
    tbl.push_back(mk(ALU_XOR, 0, 0, C_NONE, 0, 0, 32'hF0F0,
                     32'hFF00, 0, 32'h0FF0, 0, 0));
    tbl.push_back(mk(ALU_SLL, 0, 1, C_NONE, 0, 0, 1, 0, 32'h21,
                     32'd2, 0, 0));
    tbl.push_back(mk(ALU_SRL, 0, 1, C_NONE, 0, 0, 32'h8000_0000,
                     0, 4, 32'h0800_0000, 0, 0));
    tbl.push_back(mk(ALU_SRA, 0, 1, C_NONE, 0, 0, 32'h8000_0000,
                     0, 4, 32'hF800_0000, 0, 0));
    tbl.push_back(mk(ALU_SLT, 0, 0, C_NONE, 0, 0, 32'hFFFF_FFFF,
                     1, 0, 32'd1, 0, 0));
    tbl.push_back(mk(ALU_SLTU, 0, 0, C_NONE, 0, 0, 32'hFFFF_FFFF,
                     1, 0, 32'd0, 0, 0));
    tbl.push_back(mk(ALU_PASS_B, 2, 1, C_NONE, 0, 0, 9, 0,
                     32'h1234_5000, 32'h1234_5000, 0, 0));
    tbl.push_back(mk(4'd12, 0, 0, C_NONE, 0, 0, 5, 7, 0,
                     32'd0, 0, 0));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BEQ, 32'h100, 1, 2,
                     32'h20, 32'd3, 0, 0));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BLT, 32'h200,
                     32'hFFFF_FFFB, 3, 32'h10, 32'hFFFF_FFFE, 1,
                     32'h210));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 5, 7, 0,
                     32'd12, 0, 0));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BGEU, 0, 32'h10,
                     32'hFFFF_FFFF, 8, 32'h0000_000F, 0, 0));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, 3'b010, 0, 7, 7, 8,
                     32'd14, 0, 0));
    tbl.push_back(mk(ALU_ADD, 1, 2, C_JAL, 0, 32'h40, 0, 0,
                     32'h100, 32'h44, 1, 32'h140));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BEQ, 32'h80, 3, 3, 8,
                     32'd6, 1, 32'h88));
    tbl.push_back(mk(ALU_ADD, 1, 2, C_JALR, 0, 32'h40, 32'h1003, 0,
                     4, 32'h44, 1, 32'h1006));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 5, 7, 0,
                     32'd12, 0, 0));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BEQ, 32'h100, 3, 3,
                     32'h20, 32'd6, 1, 32'h120));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 5, 7, 0,
                     32'd12, 0, 0));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BGE, 32'h300, 3,
                     32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'd2, 1,
                     32'h2F0));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BLTU, 32'h400, 1, 2,
                     32'h8, 32'd3, 1, 32'h408));
    tbl.push_back(mk(ALU_ADD, 0, 0, C_BR, F3_BNE, 32'h500, 4, 4,
                     32'h8, 32'd8, 0, 0));
    tbl[25].mw = 4'hF; tbl[25].rw = 1'b0; tbl[25].f3 = F3_BNE;

    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", mem_valid_o, 0);
    chk("reset.rw", mem_reg_write_o, 0);
    chk("reset.mw", mem_mem_write_o, 0);
    chk("reset.res", mem_alu_result_o, 0);
    chk("reset.rd", mem_rd_o, 0);
    chk("reset.redirect", redirect_o, 0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Forwarding: MEM over WB, WB alone, rs2 path, x0 never forwarded
    mem_fwd_en_i = 1; mem_fwd_rd_i = 2; mem_fwd_data_i = 32'hAA;
    wb_fwd_en_i = 1; wb_fwd_rd_i = 2; wb_fwd_data_i = 32'hBB;
    v = mk(ALU_SUB, 0, 0, C_NONE, 0, 0, 32'h55, 32'h0A, 0, 0, 0, 0);
    v.rs1 = 2; v.rs2 = 3;
`ifdef EXECUTE_FORWARD_EN
    v.res = 32'hA0;
`else
    v.res = 32'h4B;
`endif
    run_vec("fwd_mem", v);
    mem_fwd_rd_i = 5;
`ifdef EXECUTE_FORWARD_EN
    v.res = 32'hB1;
`else
    v.res = 32'h4B;
`endif
    run_vec("fwd_wb", v);
    mem_fwd_rd_i = 2; wb_fwd_en_i = 0;
    v = mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 1, 0, 0, 0, 0, 0);
    v.rs1 = 4; v.rs2 = 2;
`ifdef EXECUTE_FORWARD_EN
    v.res = 32'hAB; v.wd = 32'hAA;
`else
    v.res = 32'h1; v.wd = 32'h0;
`endif
    run_vec("fwd_rs2", v);
    mem_fwd_rd_i = 0; wb_fwd_en_i = 1; wb_fwd_rd_i = 0;
    v = mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 0, 32'h0A, 0, 32'h0A, 0, 0);
    v.rs1 = 0; v.rs2 = 3;
    run_vec("fwd_x0", v);
    mem_fwd_en_i = 0; wb_fwd_en_i = 0;

    // Taken BNE held off by a two-cycle stall
    run_vec("pre_stall", mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 20, 22, 0,
                            32'd42, 0, 0));
    drive(mk(ALU_SUB, 0, 0, C_BR, F3_BNE, 32'h500, 1, 2, 32'h40,
             0, 1, 0));
    mem_stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall.redirect", redirect_o, 0);
      chk("stall.ready", ex_ready_o, 0);
      @(posedge clk);
      #1;
      chk("stall.hold_res", mem_alu_result_o, 32'd42);
      chk("stall.hold_valid", mem_valid_o, 1);
    end
    mem_stall_i = 1'b0;
    #1;
    chk("unstall.redirect", redirect_o, 1);
    chk("unstall.redirect_pc", redirect_pc_o, 32'h540);
    chk("unstall.ready", ex_ready_o, 1);
    @(posedge clk);
    #1;
    chk("unstall.res", mem_alu_result_o, 32'hFFFF_FFFF);
    chk("unstall.valid", mem_valid_o, 1);
    sq = 1'b1;

    // Squash persists across a stall on the wrong-path slot
    drive(mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 5, 7, 0, 0, 0, 0));
    mem_stall_i = 1'b1;
    #1;
    chk("sqstall.redirect", redirect_o, 0);
    @(posedge clk);
    #1;
    chk("sqstall.hold_res", mem_alu_result_o, 32'hFFFF_FFFF);
    mem_stall_i = 1'b0;
    @(posedge clk);
    #1;
    chk("sqstall.bubble_valid", mem_valid_o, 0);
    chk("sqstall.bubble_rw", mem_reg_write_o, 0);
    sq = 1'b0;
    run_vec("post_squash", mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 1, 2, 0,
                              32'd3, 0, 0));

    // Reset while squash is pending and stall is high
    run_vec("pre_rst_jal", mk(ALU_ADD, 1, 2, C_JAL, 0, 32'h60, 0, 0,
                              32'h20, 32'h64, 1, 32'h80));
    drive(mk(ALU_ADD, 1, 2, C_JAL, 0, 32'h70, 0, 0, 32'h20, 0, 0, 0));
    reset = 1'b1; mem_stall_i = 1'b1;
    #1;
    chk("rst.redirect", redirect_o, 0);
    @(posedge clk);
    #1;
    chk("rst.valid", mem_valid_o, 0);
    chk("rst.rw", mem_reg_write_o, 0);
    chk("rst.mw", mem_mem_write_o, 0);
    chk("rst.res", mem_alu_result_o, 0);
    chk("rst.wd", mem_write_data_o, 0);
    chk("rst.rd", mem_rd_o, 0);
    chk("rst.rsrc", mem_result_src_o, 0);
    chk("rst.f3", mem_funct3_o, 0);
    reset = 1'b0;
    sq = 1'b0;
    run_vec("post_rst", mk(ALU_ADD, 0, 0, C_NONE, 0, 0, 5, 7, 0,
                           32'd12, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
